word_loader: RTL

WORD_LOADER -- requirements
Module: word_loader

---
 rtl/word_loader_pkg.sv | 13 +
 rtl/word_loader.sv | 97 +++++++++
 2 files changed

// File: rtl/word_loader_pkg.sv
// Types and constants shared by the word loader and the matcher that consumes its SRAM.
package word_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    TERM,
    HOLD
  } loader_state_e;

  localparam int unsigned NULL_CHAR = 0;

endpackage

// File: rtl/word_loader.sv
// Streams characters into an external word SRAM, null-terminates the word and
// holds it resident until the matcher acknowledges it.
module word_loader
  import word_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  word_valid,
  input  logic                  word_ack,
  output logic [ADDR_WIDTH-1:0] word_len,
  output logic                  trunc_err
);

  // Last address is reserved for the terminator.
  localparam logic [ADDR_WIDTH-1:0] PtrMax = '1;

  loader_state_e         state_q;
  logic [ADDR_WIDTH-1:0] ptr_q;

  logic accept;
  logic is_null;
  logic full;

  always_comb begin
    in_ready = !rst && ((state_q == IDLE) || (state_q == LOAD));
    accept   = in_valid && in_ready;
    is_null  = (in_data == DATA_WIDTH'(NULL_CHAR));
    full     = (ptr_q == PtrMax);
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    if (!rst) begin
      if (state_q == TERM) begin
        wr_en   = 1'b1;
        wr_addr = ptr_q;
        wr_data = DATA_WIDTH'(NULL_CHAR);
      end else if (accept && !is_null && !full) begin
        // ptr_q is always 0 in IDLE, so this also covers the first character.
        wr_en   = 1'b1;
        wr_addr = ptr_q;
        wr_data = in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      word_valid <= 1'b0;
      word_len   <= '0;
      trunc_err  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, LOAD: begin
          if (accept) begin
            if (is_null) begin
              state_q <= TERM;
            end else begin
              if (full) begin
                trunc_err <= 1'b1;
              end else begin
                ptr_q <= ptr_q + 1'b1;
              end
              state_q <= in_last ? TERM : LOAD;
            end
          end
        end
        TERM: begin
          word_len   <= ptr_q;
          word_valid <= 1'b1;
          state_q    <= HOLD;
        end
        HOLD: begin
          if (word_ack) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            word_valid <= 1'b0;
            trunc_err  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
